reel_sequencer: RTL and testbench
=================================

Name: reel_sequencer

Overview:
Central controller for the three-reel slot machine. Replaces the single shared run signal with per-reel run enables and stops reels left, middle, right on a staggered timed schedule. Evaluates the settled reel digits, maintains a credit balance, and drives buzzer and blink-enable during payout. Sits between the button input, the reel modules (via `reel_run`), and the display/buzzer path.

Parameters:
- TICK_DIV, 50000: clk cycles per internal tick (one tick = 1 ms at 50 MHz).
- MIN_SPIN_TICKS, 800: ticks all reels spin before the left reel stops.
- STAGGER_TICKS, 300: ticks between successive reel stops.
- SETTLE_TICKS, 2: ticks after the last stop before reel values are sampled.
- BUZZ_TICKS, 500: payout buzzer/blink duration in ticks.
- CREDIT_INIT, 5: credits after reset.
- PAY_PAIR, 2: credits paid for exactly two equal reels.
- PAY_TRIPLE, 10: credits paid for three equal reels.
- CREDIT_MAX, 99: credit saturation value.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- button  in  1  raw push button, asynchronous to clk.
- reel_vals  in  [2:0][3:0]  current digit per reel; index 0 = left.
- reel_run  out  [2:0]  per-reel run enable; bit 0 = left.
- busy  out  1  high in every state except IDLE.
- win_type  out  2  0 none, 1 pair, 2 triple; 3 unused.
- credits  out  7  credit balance, 0..CREDIT_MAX.
- buzzer  out  1  high during PAYOUT.
- blink  out  1  display blink enable, high during PAYOUT.

Behaviour:
- Reset (rst=0, async): state IDLE; reel_run=000; busy=0; win_type=0; credits=CREDIT_INIT; buzzer=0; blink=0; tick prescaler and tick counter = 0; sync flops = 0.
- Button path:
  - Two-flop synchronizer followed by a rising-edge detect.
  - A pin rise produces exactly one `press` pulse; reel_run rises on the 3rd clk edge after the pin rises.
  - Holding the button produces no further presses.
- Ticks:
  - Prescaler emits a 1-cycle tick every TICK_DIV clk.
  - Prescaler and tick counter clear on every state entry, so each interval is exact to ±0 clk.
- States:
  - IDLE: press with credits>0 → credits−1, reel_run=111, win_type=0, go to SPIN. Press with credits=0 is ignored; stay IDLE.
  - SPIN: after MIN_SPIN_TICKS ticks → reel_run[0]=0, go to STOP_L.
  - STOP_L: after STAGGER_TICKS → reel_run[1]=0, go to STOP_M.
  - STOP_M: after STAGGER_TICKS → reel_run[2]=0, go to SETTLE.
  - SETTLE: after SETTLE_TICKS, sample reel_vals and go to EVAL (1 clk).
  - EVAL, all three equal: win_type=2, credits += PAY_TRIPLE, go to PAYOUT.
  - EVAL, exactly two equal (any pair): win_type=1, credits += PAY_PAIR, go to PAYOUT.
  - EVAL, no match: win_type=0, go to IDLE.
  - PAYOUT: buzzer=1, blink=1 for BUZZ_TICKS, then IDLE.
- Arithmetic: credit add saturates at CREDIT_MAX; the subtract never underflows because of the IDLE guard.
- win_type holds its value until the next accepted spin.
- Presses outside IDLE are ignored (unless the optional feature is compiled in).
- Reset asserted mid-spin: all outputs return to reset values immediately, independent of clk.
- Parameters with value 0 are treated as 1.

Optional Feature:
- Macro: `SKILL_STOP_EN`.
- Defined: in STOP_L or STOP_M, a press ends the current stagger interval immediately and stops the next reel on the following clk. In SPIN, presses stay ignored, so MIN_SPIN_TICKS is always honoured.
- Undefined: stops are purely timed; the logic is absent.

Decomposition:
- Package `slot_pkg`: state enum (IDLE, SPIN, STOP_L, STOP_M, SETTLE, EVAL, PAYOUT), win_t enum, NUM_REELS=3, DIGIT_W=4, CREDIT_W=7.
- Sub-module `tick_strobe` (parameter DIV; ports clk, rst, clr, tick): the restartable prescaler.

Test Plan (bench parameters TICK_DIV=4, MIN_SPIN_TICKS=5, STAGGER_TICKS=3, SETTLE_TICKS=1, BUZZ_TICKS=2):
- Press after reset → credits 5→4; reel_run=111 on 3rd clk; bits clear at 20, 32, 44 clk after the spin starts.
- Reels settle to 7,7,7 → win_type=2, credits 4→14, buzzer and blink high for exactly 8 clk, then IDLE.
- Reels settle to 3,9,3 → win_type=1, credits +2; reels 1,2,3 → win_type=0, no buzzer, IDLE right after EVAL.
- Credits 0, press → no reel_run, busy stays 0; force credits to 95 plus a triple → credits=99.
- Button held 200 clk and presses during SPIN → exactly one spin; reset pulled low in STOP_M → reel_run=000 and credits=5 asynchronously.
- With `SKILL_STOP_EN`: press in STOP_L → reel_run[1] clears 1 clk after the press pulse; press in SPIN → no effect.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and helpers for the three-reel slot machine controller.
package slot_pkg;

  localparam int NUM_REELS = 3;
  localparam int DIGIT_W   = 4;
  localparam int CREDIT_W  = 7;

  typedef enum logic [2:0] {
    IDLE,
    SPIN,
    STOP_L,
    STOP_M,
    SETTLE,
    EVAL,
    PAYOUT
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE   = 2'd0,
    WIN_PAIR   = 2'd1,
    WIN_TRIPLE = 2'd2
  } win_t;

  // A zero-valued count or duration parameter behaves as 1.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic win_t classify(input logic [NUM_REELS-1:0][DIGIT_W-1:0] v);
    if (v[0] == v[1] && v[1] == v[2]) return WIN_TRIPLE;
    if (v[0] == v[1] || v[1] == v[2] || v[0] == v[2]) return WIN_PAIR;
    return WIN_NONE;
  endfunction

endpackage

// File: rtl/tick_strobe.sv
// Restartable prescaler: one-cycle tick every DIV clocks, realigned by clr.
module tick_strobe
  import slot_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV_EFF = at_least_one(DIV);
  localparam int CW      = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV_EFF - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/reel_sequencer.sv
// Slot machine controller: staggered reel stops, win evaluation, credits, payout.
// Optional build macro SKILL_STOP_EN: a press in STOP_L/STOP_M stops the next reel early.
module reel_sequencer
  import slot_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int MIN_SPIN_TICKS = 800,
  parameter int STAGGER_TICKS  = 300,
  parameter int SETTLE_TICKS   = 2,
  parameter int BUZZ_TICKS     = 500,
  parameter int CREDIT_INIT    = 5,
  parameter int PAY_PAIR       = 2,
  parameter int PAY_TRIPLE     = 10,
  parameter int CREDIT_MAX     = 99
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              button,
  input  logic [NUM_REELS-1:0][DIGIT_W-1:0] reel_vals,
  output logic [NUM_REELS-1:0]              reel_run,
  output logic                              busy,
  output logic [1:0]                        win_type,
  output logic [CREDIT_W-1:0]               credits,
  output logic                              buzzer,
  output logic                              blink
);

  localparam int MIN_EFF     = at_least_one(MIN_SPIN_TICKS);
  localparam int STAG_EFF    = at_least_one(STAGGER_TICKS);
  localparam int SETTLE_EFF  = at_least_one(SETTLE_TICKS);
  localparam int BUZZ_EFF    = at_least_one(BUZZ_TICKS);
  localparam int INIT_EFF    = at_least_one(CREDIT_INIT);
  localparam int PAIR_EFF    = at_least_one(PAY_PAIR);
  localparam int TRIPLE_EFF  = at_least_one(PAY_TRIPLE);
  localparam int MAX_EFF     = at_least_one(CREDIT_MAX);

  state_t                              state;
  logic [2:0]                          btn_q;
  logic                                press;
  logic                                tick;
  logic                                skill_stop;
  logic                                interval_done;
  logic                                advance;
  logic [31:0]                         tick_cnt;
  int                                  limit;
  logic [NUM_REELS-1:0][DIGIT_W-1:0]   sampled;
  win_t                                eval_win;

  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] c, input int pay);
    int sum;
    sum = int'(c) + pay;
    return (sum > MAX_EFF) ? CREDIT_W'(MAX_EFF) : CREDIT_W'(sum);
  endfunction

  // Two synchronizer flops plus one history flop for the rising-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_q <= '0;
    else      btn_q <= {btn_q[1:0], button};
  end

  assign press = btn_q[1] & ~btn_q[2];

`ifdef SKILL_STOP_EN
  assign skill_stop = press && (state == STOP_L || state == STOP_M);
`else
  assign skill_stop = 1'b0;
`endif

  tick_strobe #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (advance),
    .tick (tick)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    limit = 1;
    case (state)
      SPIN:          limit = MIN_EFF;
      STOP_L, STOP_M: limit = STAG_EFF;
      SETTLE:        limit = SETTLE_EFF;
      PAYOUT:        limit = BUZZ_EFF;
      default:       limit = 1;
    endcase
  end

  assign interval_done = tick && (tick_cnt == 32'(limit - 1));

  // advance marks the cycle that leaves the current state; it also restarts the prescaler.
  always_comb begin
    advance = 1'b0;
    case (state)
      IDLE:           advance = press && (credits != '0);
      SPIN, SETTLE,
      PAYOUT:         advance = interval_done;
      STOP_L, STOP_M: advance = interval_done || skill_stop;
      EVAL:           advance = 1'b1;
      default:        advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         tick_cnt <= '0;
    else if (advance)                 tick_cnt <= '0;
    else if (tick && state != IDLE)   tick_cnt <= tick_cnt + 1'b1;
  end

  // NOTE: the sampled reel digits are pure data consumed only in EVAL, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == SETTLE && advance) sampled <= reel_vals;
  end

  assign eval_win = classify(sampled);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      reel_run <= '0;
      busy     <= 1'b0;
      win_type <= WIN_NONE;
      credits  <= CREDIT_W'(INIT_EFF);
      buzzer   <= 1'b0;
      blink    <= 1'b0;
    end else if (advance) begin
      case (state)
        IDLE: begin
          credits  <= credits - 1'b1;
          reel_run <= '1;
          win_type <= WIN_NONE;
          busy     <= 1'b1;
          state    <= SPIN;
        end
        SPIN: begin
          reel_run[0] <= 1'b0;
          state       <= STOP_L;
        end
        STOP_L: begin
          reel_run[1] <= 1'b0;
          state       <= STOP_M;
        end
        STOP_M: begin
          reel_run[2] <= 1'b0;
          state       <= SETTLE;
        end
        SETTLE: state <= EVAL;
        EVAL: begin
          win_type <= eval_win;
          case (eval_win)
            WIN_TRIPLE: begin
              credits <= sat_add(credits, TRIPLE_EFF);
              buzzer  <= 1'b1;
              blink   <= 1'b1;
              state   <= PAYOUT;
            end
            WIN_PAIR: begin
              credits <= sat_add(credits, PAIR_EFF);
              buzzer  <= 1'b1;
              blink   <= 1'b1;
              state   <= PAYOUT;
            end
            default: begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          endcase
        end
        PAYOUT: begin
          buzzer <= 1'b0;
          blink  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reel_sequencer.sv
// Self-checking bench for reel_sequencer with short timing parameters and a spec-level model.
module tb_reel_sequencer;

  localparam int DIV = 4, MIN = 5, STAG = 3, SET = 1, BUZZ = 2;
  localparam int C_INIT = 5, P_PAIR = 2, P_TRIP = 10, C_MAX = 99;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             button = 1'b0;
  logic [2:0][3:0]  reel_vals = '0;
  logic [2:0]       reel_run;
  logic             busy;
  logic [1:0]       win_type;
  logic [6:0]       credits;
  logic             buzzer;
  logic             blink;

  int n_checks = 0;
  int n_fail   = 0;
  int model_credits;
  int last_win;

  reel_sequencer #(
    .TICK_DIV(DIV), .MIN_SPIN_TICKS(MIN), .STAGGER_TICKS(STAG), .SETTLE_TICKS(SET),
    .BUZZ_TICKS(BUZZ), .CREDIT_INIT(C_INIT), .PAY_PAIR(P_PAIR), .PAY_TRIPLE(P_TRIP),
    .CREDIT_MAX(C_MAX)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .reel_vals(reel_vals),
    .reel_run(reel_run), .busy(busy), .win_type(win_type), .credits(credits),
    .buzzer(buzzer), .blink(blink)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int win_of(input int a, input int b, input int c);
    if (a == b && b == c) return 2;
    if (a == b || b == c || a == c) return 1;
    return 0;
  endfunction

  // Full spin from pin rise to return to IDLE; times are in clocks after the spin-start edge.
  task automatic run_spin(input int a, input int b, input int c, input int hold,
                          input int poke, input string tag);
    int t_clr[3];
    int t_idle, n_buzz, n_blink, w, pay, ev, exp_idle, last;
    reel_vals[0] = 4'(a);
    reel_vals[1] = 4'(b);
    reel_vals[2] = 4'(c);
    check({tag, ".win_held"}, win_type, last_win);
    @(negedge clk);
    button = 1'b1;
    repeat (2) @(posedge clk);
    #1 check({tag, ".pre_run"}, reel_run, 0);
    @(posedge clk);
    #1;
    model_credits--;
    check({tag, ".start_run"}, reel_run, 3'b111);
    check({tag, ".start_busy"}, busy, 1);
    check({tag, ".start_cred"}, credits, model_credits);
    check({tag, ".start_win"}, win_type, 0);
    t_clr = '{-1, -1, -1};
    t_idle = -1; n_buzz = 0; n_blink = 0; last = 0;
    for (int k = 1; k <= 200 && t_idle < 0; k++) begin
      if (k - 1 == hold) button = 1'b0;
      if (k - 1 == poke) button = 1'b1;
      if (k - 1 == poke + 3) button = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (t_clr[i] < 0 && !reel_run[i]) t_clr[i] = k;
      if (buzzer) n_buzz++;
      if (blink) n_blink++;
      if (!busy) t_idle = k;
      last = k;
    end
    w   = win_of(a, b, c);
    pay = (w == 2) ? P_TRIP : (w == 1) ? P_PAIR : 0;
    ev  = (MIN + 2 * STAG + SET) * DIV;
    exp_idle = ev + 1 + ((w != 0) ? BUZZ * DIV : 0);
    model_credits = (model_credits + pay > C_MAX) ? C_MAX : model_credits + pay;
    check({tag, ".clr_left"}, t_clr[0], MIN * DIV);
    check({tag, ".clr_mid"}, t_clr[1], (MIN + STAG) * DIV);
    check({tag, ".clr_right"}, t_clr[2], (MIN + 2 * STAG) * DIV);
    check({tag, ".idle_at"}, t_idle, exp_idle);
    check({tag, ".buzz_len"}, n_buzz, (w != 0) ? BUZZ * DIV : 0);
    check({tag, ".blink_len"}, n_blink, (w != 0) ? BUZZ * DIV : 0);
    check({tag, ".win"}, win_type, w);
    check({tag, ".cred"}, credits, model_credits);
    last_win = w;
    if (button) begin
      if (hold > last) repeat (hold - last) @(posedge clk);
      button = 1'b0;
      repeat (6) @(posedge clk);
      #1 check({tag, ".held_no_respin"}, busy, 0);
    end
  endtask

  initial begin
    int guard;
    int t_clr[3];
    int t_idle;
    model_credits = C_INIT;
    last_win = 0;

    #12;
    check("reset.run", reel_run, 0);
    check("reset.busy", busy, 0);
    check("reset.cred", credits, C_INIT);
    check("reset.win", win_type, 0);
    check("reset.buzz", buzzer, 0);
    check("reset.blink", blink, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    run_spin(7, 7, 7, 4, -1, "triple");
    run_spin(3, 9, 3, 4, 5, "pair_poke");
    run_spin(1, 2, 3, 200, -1, "none_held");

    for (int r = 0; r < 8; r++)
      run_spin($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 4, -1, "rand");

    guard = 0;
    while (model_credits < 91 && guard < 40) begin
      run_spin(7, 7, 7, 4, -1, "climb");
      guard++;
    end
    run_spin(7, 7, 7, 4, -1, "saturate");
    check("saturate.cred_max", credits, C_MAX);

    guard = 0;
    while (model_credits > 0 && guard < 120) begin
      run_spin(1, 2, 3, 4, -1, "drain");
      guard++;
    end
    check("zero.cred", credits, 0);
    @(negedge clk);
    button = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("zero.run3", reel_run, 0);
    repeat (5) @(posedge clk);
    #1;
    check("zero.run8", reel_run, 0);
    check("zero.busy", busy, 0);
    button = 1'b0;

    // Reset pulled low mid-cycle while the right reel is still spinning.
    @(negedge clk);
    rst = 1'b0;
    #2 rst = 1'b1;
    model_credits = C_INIT;
    last_win = 0;
    reel_vals[0] = 4'd1; reel_vals[1] = 4'd2; reel_vals[2] = 4'd3;
    @(negedge clk);
    button = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("areset.started", reel_run, 3'b111);
    button = 1'b0;
    repeat (35) @(posedge clk);
    #2 check("areset.in_stop_m", reel_run, 3'b100);
    rst = 1'b0;
    #1;
    check("areset.run", reel_run, 0);
    check("areset.cred", credits, C_INIT);
    check("areset.busy", busy, 0);
    check("areset.buzz", buzzer, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

`ifdef SKILL_STOP_EN
    reel_vals[0] = 4'd1; reel_vals[1] = 4'd2; reel_vals[2] = 4'd3;
    @(negedge clk);
    button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_credits--;
    check("skill.start", reel_run, 3'b111);
    button = 1'b0;
    t_clr = '{-1, -1, -1};
    t_idle = -1;
    for (int k = 1; k <= 200 && t_idle < 0; k++) begin
      if (k - 1 == 8) button = 1'b1;
      if (k - 1 == 11) button = 1'b0;
      if (k - 1 == 22) button = 1'b1;
      if (k - 1 == 26) button = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (t_clr[i] < 0 && !reel_run[i]) t_clr[i] = k;
      if (!busy) t_idle = k;
    end
    check("skill.clr_left", t_clr[0], MIN * DIV);
    check("skill.clr_mid", t_clr[1], 22 + 3);
    check("skill.clr_right", t_clr[2], 22 + 3 + STAG * DIV);
    check("skill.idle_at", t_idle, 22 + 3 + (STAG + SET) * DIV + 1);
    check("skill.cred", credits, model_credits);
`else
    t_clr = '{-1, -1, -1};
    t_idle = -1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
